sram_arbiter: RTL and testbench

Two-port arbiter that shares the single SRAM controller between the data-memory stage (port 0) and instruction fetch (port 1). Each port presents the same read/write/address/data/ready protocol the SRAM controller itself exposes, so either pipeline stage stalls on its own `ready` exactly as it would when wired directly. The arbiter latches the winning request, sequences one complete controller transaction, and returns the 64-bit read data to the owner.

---
 rtl/sram_arb_pkg.sv | 34 +++
 rtl/sram_arb_pick.sv | 41 ++++
 rtl/sram_arbiter.sv | 164 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// ============================================================================
//  Module   : sram_arb_pkg
//  Purpose  : Shared definitions for the two-port SRAM arbiter: FSM state
//             encoding, requester port ids and transaction op encoding.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_arb_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    // Latched transaction type; write wins when a port raises rd and wr together
    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } arb_op_t;

    // Requester ids
    localparam logic PORT_DMEM   = 1'b0;
    localparam logic PORT_IFETCH = 1'b1;

    localparam int ADDR_W  = 32;
    localparam int WDATA_W = 32;
    localparam int RDATA_W = 64;

endpackage

`default_nettype wire

// File: rtl/sram_arb_pick.sv
// ============================================================================
//  Module   : sram_arb_pick
//  Purpose  : Combinational winner select between the data-memory port (0)
//             and the instruction-fetch port (1).
//             SRAM_ARB_RR_EN defined  : round-robin, ptr names preferred port.
//             SRAM_ARB_RR_EN undefined: fixed priority, port 0 wins ties.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic [1:0] req,
`ifdef SRAM_ARB_RR_EN
    input  logic       ptr,
`endif
    output logic       valid,
    output logic       winner
);

    // A sole requester always wins; only a tie consults the policy
    always_comb begin
        valid  = |req;
        winner = PORT_DMEM;
`ifdef SRAM_ARB_RR_EN
        if (req == 2'b11) begin
            winner = ptr;
        end else if (req[1]) begin
            winner = PORT_IFETCH;
        end
`else
        if (!req[0] && req[1]) begin
            winner = PORT_IFETCH;
        end
`endif
    end

endmodule

`default_nettype wire

// File: rtl/sram_arbiter.sv
// ============================================================================
//  Module   : sram_arbiter
//  Purpose  : Shares one SRAM controller between the data-memory stage
//             (port 0) and instruction fetch (port 1). Latches the winning
//             request, runs one controller transaction, returns read data.
//  Options  : SRAM_ARB_RR_EN - round-robin arbitration (default: fixed
//             priority, port 0 first).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NPORTS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                p0_rd,
    input  logic                p0_wr,
    input  logic [ADDR_W-1:0]   p0_addr,
    input  logic [WDATA_W-1:0]  p0_wdata,
    output logic [RDATA_W-1:0]  p0_rdata,
    output logic                p0_ready,
    input  logic                p1_rd,
    input  logic                p1_wr,
    input  logic [ADDR_W-1:0]   p1_addr,
    input  logic [WDATA_W-1:0]  p1_wdata,
    output logic [RDATA_W-1:0]  p1_rdata,
    output logic                p1_ready,
    output logic                mem_read_en,
    output logic                mem_write_en,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [WDATA_W-1:0]  mem_data,
    input  logic [RDATA_W-1:0]  mem_readData,
    input  logic                mem_ready
);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    arb_op_t             r_op;
    logic                r_owner;
    logic [ADDR_W-1:0]   r_addr;
    logic [WDATA_W-1:0]  r_wdata;
    logic [RDATA_W-1:0]  r_p0_rdata;
    logic [RDATA_W-1:0]  r_p1_rdata;

    logic [NPORTS-1:0]   w_req;
    logic                w_req_any;
    logic                w_winner;
    logic                w_grant;
    logic                w_win_wr;

    assign w_req    = {p1_rd | p1_wr, p0_rd | p0_wr};
    assign w_grant  = (r_state == IDLE) && w_req_any;
    assign w_win_wr = (w_winner == PORT_IFETCH) ? p1_wr : p0_wr;

`ifdef SRAM_ARB_RR_EN
    logic r_ptr;

    // Preference moves to the port that lost (or did not compete) after each grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= PORT_DMEM;
        end else if (w_grant) begin
            r_ptr <= ~w_winner;
        end
    end

    sram_arb_pick u_pick (
        .req    (w_req),
        .ptr    (r_ptr),
        .valid  (w_req_any),
        .winner (w_winner)
    );
`else
    sram_arb_pick u_pick (
        .req    (w_req),
        .valid  (w_req_any),
        .winner (w_winner)
    );
`endif

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and controller/ready decode
    always_comb begin
        w_state_nxt  = r_state;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        p0_ready     = ~(p0_rd | p0_wr);
        p1_ready     = ~(p1_rd | p1_wr);
        case (r_state)
            IDLE: begin
                if (w_req_any) begin
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                mem_read_en  = (r_op == READ);
                mem_write_en = (r_op == WRITE);
                if (mem_ready) begin
                    w_state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                // Enables low here so the controller can clear its counter
                if (r_owner == PORT_DMEM) begin
                    p0_ready = 1'b1;
                end else begin
                    p1_ready = 1'b1;
                end
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Capture the winning request; it is committed until RELEASE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner <= PORT_DMEM;
            r_op    <= READ;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant) begin
            r_owner <= w_winner;
            r_op    <= w_win_wr ? WRITE : READ;
            r_addr  <= (w_winner == PORT_IFETCH) ? p1_addr  : p0_addr;
            r_wdata <= (w_winner == PORT_IFETCH) ? p1_wdata : p0_wdata;
        end
    end

    // Per-port read data, held until that port's next read completes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p0_rdata <= '0;
            r_p1_rdata <= '0;
        end else if ((r_state == BUSY) && mem_ready && (r_op == READ)) begin
            if (r_owner == PORT_DMEM) begin
                r_p0_rdata <= mem_readData;
            end else begin
                r_p1_rdata <= mem_readData;
            end
        end
    end

    assign mem_address = r_addr;
    assign mem_data    = r_wdata;
    assign p0_rdata    = r_p0_rdata;
    assign p1_rdata    = r_p1_rdata;

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ============================================================================
//  Module   : tb_sram_arbiter
//  Purpose  : Self-checking bench for sram_arbiter with a latency-5 SRAM
//             controller model returning {addr, ~addr}.
//  Options  : SRAM_ARB_RR_EN selects round-robin expectations.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_arbiter;

    localparam int L = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        p0_rd = 1'b0, p0_wr = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0;
    logic [63:0] p0_rdata;
    logic        p0_ready;
    logic        p1_rd = 1'b0, p1_wr = 1'b0;
    logic [31:0] p1_addr = '0, p1_wdata = '0;
    logic [63:0] p1_rdata;
    logic        p1_ready;
    logic        mem_read_en, mem_write_en;
    logic [31:0] mem_address, mem_data;
    logic [63:0] mem_readData;
    logic        mem_ready;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int en_cnt = 0;
    int ctl_cnt = 0;

    sram_arbiter #(.NPORTS(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .p0_rd        (p0_rd),
        .p0_wr        (p0_wr),
        .p0_addr      (p0_addr),
        .p0_wdata     (p0_wdata),
        .p0_rdata     (p0_rdata),
        .p0_ready     (p0_ready),
        .p1_rd        (p1_rd),
        .p1_wr        (p1_wr),
        .p1_addr      (p1_addr),
        .p1_wdata     (p1_wdata),
        .p1_rdata     (p1_rdata),
        .p1_ready     (p1_ready),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .mem_readData (mem_readData),
        .mem_ready    (mem_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Controller model: ready on the L-th consecutive cycle of asserted enable
    always @(posedge clk) begin
        if (mem_read_en || mem_write_en) ctl_cnt <= ctl_cnt + 1;
        else                             ctl_cnt <= 0;
    end
    assign mem_ready    = (mem_read_en || mem_write_en) && (ctl_cnt == L - 1);
    assign mem_readData = {mem_address, ~mem_address};

    always @(negedge clk) if (mem_read_en || mem_write_en) en_cnt <= en_cnt + 1;

    // ---------------- behavioural model ----------------
    // m_left counts cycles to the end of the current job: L busy cycles, then
    // one release cycle (m_left==1); 0 means free to accept a request.
    int          m_left = 0;
    logic        m_owner = 1'b0;
    logic        m_wr = 1'b0;
    logic        m_ptr = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [63:0] m_rdata [2] = '{64'd0, 64'd0};

    function automatic logic pick(input logic r0, input logic r1, input logic ptr);
        if (r0 && r1) begin
`ifdef SRAM_ARB_RR_EN
            return ptr;
`else
            return 1'b0;
`endif
        end
        return r1 && !r0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_left     <= 0;
            m_owner    <= 1'b0;
            m_wr       <= 1'b0;
            m_ptr      <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_rdata[0] <= '0;
            m_rdata[1] <= '0;
        end else if (m_left == 0) begin
            if (p0_rd || p0_wr || p1_rd || p1_wr) begin
                logic w;
                w = pick(p0_rd || p0_wr, p1_rd || p1_wr, m_ptr);
                m_owner <= w;
                m_wr    <= w ? p1_wr : p0_wr;
                m_addr  <= w ? p1_addr : p0_addr;
                m_wdata <= w ? p1_wdata : p0_wdata;
                m_ptr   <= ~w;
                m_left  <= L + 1;
            end
        end else begin
            if (m_left == 2 && !m_wr) m_rdata[m_owner] <= {m_addr, ~m_addr};
            m_left <= m_left - 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the model
    initial begin
        forever begin
            logic busy;
            @(negedge clk);
            busy = (m_left >= 2);
            check("rd_en", 64'(mem_read_en), 64'(busy && !m_wr));
            check("wr_en", 64'(mem_write_en), 64'(busy && m_wr));
            if (busy) begin
                check("mem_address", 64'(mem_address), 64'(m_addr));
                if (m_wr) check("mem_data", 64'(mem_data), 64'(m_wdata));
            end
            check("p0_ready", 64'(p0_ready),
                  64'(!(p0_rd || p0_wr) || (m_left == 1 && m_owner == 1'b0)));
            check("p1_ready", 64'(p1_ready),
                  64'(!(p1_rd || p1_wr) || (m_left == 1 && m_owner == 1'b1)));
            check("p0_rdata", p0_rdata, m_rdata[0]);
            check("p1_rdata", p1_rdata, m_rdata[1]);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a ready pulse on a requesting port; returns its cycle
    task automatic wait_pulse(input int port, output int at);
        at = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (port == 0 ? (p0_ready && (p0_rd || p0_wr)) : (p1_ready && (p1_rd || p1_wr))) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL pulse_timeout: port %0d got no ready pulse, required one within 60 cycles", port);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, e0, at, first, win, exp_win;

        cycles(2);
        rst = 1'b1;
        check("reset_rd_en", 64'(mem_read_en), 64'd0);
        check("reset_wr_en", 64'(mem_write_en), 64'd0);
        check("reset_p0_ready", 64'(p0_ready), 64'd1);
        check("reset_p1_ready", 64'(p1_ready), 64'd1);
        check("reset_p0_rdata", p0_rdata, 64'd0);
        check("reset_p1_rdata", p1_rdata, 64'd0);
        cycles(1);

        // Single port-0 read
        t0 = cyc; e0 = en_cnt;
        p0_rd = 1'b1; p0_addr = 32'h0000_0040;
        wait_pulse(0, at);
        check("t1_latency", 64'(at - t0), 64'd6);
        cycles(1); p0_rd = 1'b0;
        cycles(4);
        check("t1_enable_cycles", 64'(en_cnt - e0), 64'd5);
        check("t1_p0_rdata", p0_rdata, 64'h0000_0040_FFFF_FFBF);

        // Simultaneous reads
`ifdef SRAM_ARB_RR_EN
        first = 1;
`else
        first = 0;
`endif
        t0 = cyc;
        p0_rd = 1'b1; p0_addr = 32'h0000_0044;
        p1_rd = 1'b1; p1_addr = 32'h0000_0080;
        wait_pulse(first, at);
        check("t2_first_latency", 64'(at - t0), 64'd6);
        cycles(1);
        if (first == 0) p0_rd = 1'b0; else p1_rd = 1'b0;
        wait_pulse(1 - first, at);
        check("t2_second_latency", 64'(at - t0), 64'd13);
        cycles(1); p0_rd = 1'b0; p1_rd = 1'b0;
        cycles(1);
        check("t2_p0_rdata", p0_rdata, 64'h0000_0044_FFFF_FFBB);
        check("t2_p1_rdata", p1_rdata, 64'h0000_0080_FFFF_FF7F);

        // Port 1 rd+wr together: write wins
        t0 = cyc;
        p1_rd = 1'b1; p1_wr = 1'b1; p1_addr = 32'h0000_0100; p1_wdata = 32'hDEAD_BEEF;
        @(negedge clk); @(negedge clk); #1;
        check("t4_wr_en", 64'(mem_write_en), 64'd1);
        check("t4_rd_en", 64'(mem_read_en), 64'd0);
        check("t4_mem_data", 64'(mem_data), 64'h0000_0000_DEAD_BEEF);
        check("t4_mem_address", 64'(mem_address), 64'h0000_0000_0000_0100);
        wait_pulse(1, at);
        check("t4_latency", 64'(at - t0), 64'd6);
        cycles(1); p1_rd = 1'b0; p1_wr = 1'b0;
        cycles(1);
        check("t4_p1_rdata_kept", p1_rdata, 64'h0000_0080_FFFF_FF7F);

        // Port 0 drops its read mid-BUSY
        t0 = cyc; e0 = en_cnt;
        p0_rd = 1'b1; p0_addr = 32'h0000_0300;
        cycles(2);
        p0_rd = 1'b0;
        cycles(10);
        check("t5_enable_cycles", 64'(en_cnt - e0), 64'd5);
        check("t5_p0_rdata", p0_rdata, 64'h0000_0300_FFFF_FCFF);

        // Reset during the third BUSY cycle
        p0_rd = 1'b1; p0_addr = 32'h0000_0500;
        cycles(3);
        #1;
        rst = 1'b0; p0_rd = 1'b0;
        #1;
        check("t6_rd_en", 64'(mem_read_en), 64'd0);
        check("t6_wr_en", 64'(mem_write_en), 64'd0);
        check("t6_p0_rdata", p0_rdata, 64'd0);
        check("t6_p1_rdata", p1_rdata, 64'd0);
        check("t6_p0_ready", 64'(p0_ready), 64'd1);
        check("t6_p1_ready", 64'(p1_ready), 64'd1);
        cycles(1);
        rst = 1'b1;
        cycles(1);
        t0 = cyc;
        p1_rd = 1'b1; p1_addr = 32'h0000_0600;
        wait_pulse(1, at);
        check("t6_post_latency", 64'(at - t0), 64'd6);
        cycles(1); p1_rd = 1'b0;
        cycles(1);
        check("t6_p1_rdata", p1_rdata, 64'h0000_0600_FFFF_F9FF);

        // Both ports held for four transactions
        cycles(1);
        t0 = cyc;
        p0_rd = 1'b1; p0_addr = 32'h0000_0010;
        p1_rd = 1'b1; p1_addr = 32'h0000_0020;
        for (int k = 0; k < 4; k++) begin
            win = -1;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                #1;
                if (p0_ready) begin win = 0; break; end
                if (p1_ready) begin win = 1; break; end
            end
`ifdef SRAM_ARB_RR_EN
            exp_win = k % 2;
`else
            exp_win = 0;
`endif
            check("t3_grant_order", 64'(win), 64'(exp_win));
            check("t3_grant_time", 64'(cyc - t0), 64'(6 + 7 * k));
        end
        cycles(1); p0_rd = 1'b0; p1_rd = 1'b0;
        cycles(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
